// File: rtl/ifetch_mem_responder.sv
// ----------------------------------------------------------------------------
// ifetch_mem_responder
//
// Responder end of the core instruction-fetch port. Fetch requests are taken
// over a valid/ready handshake, the 128-bit line holding the requested byte
// address is read from on-chip instruction memory in the accept cycle, and the
// result travels a READ_LATENCY-deep pipeline to a one-cycle rsp_valid pulse.
// After reset the memory is cleared one line per cycle before fetches are
// served. Lines can be preloaded from the boot path, and a redirect flush
// drops every response still in flight.
//
// Optional feature macro: IFETCH_RESP_PARITY_EN
//   When defined, each line also stores 4 even-parity bits (one per 32-bit
//   word). The parity_inject port corrupts the stored bits on load. A parity
//   mismatch on read raises rsp_error while the data is still returned.
//
// Ports
//   core_clk_main_800mhz  in   clock, rising edge
//   core_reset_async_n    in   asynchronous active-low reset
//   req_addr              in   fetch byte address (low 4 bits ignored)
//   req_valid             in   fetch request valid
//   req_ready             out  request can be accepted this cycle
//   rsp_data              out  returned line (held between pulses)
//   rsp_valid             out  one-cycle response pulse
//   rsp_error             out  out-of-range (or parity) error, held with data
//   flush                 in   drop all previously accepted requests
//   load_en               in   write load_data to line load_index
//   load_index            in   preload line index
//   load_data             in   preload line data
//   parity_inject         in   (IFETCH_RESP_PARITY_EN only) corrupt parity on load
//   init_done             out  memory clear complete
//
// FSM states
//   state    | meaning
//   ST_INIT  | clearing memory, one line per cycle; no requests accepted
//   ST_SERVE | serving fetches and loads; left only by reset
// ----------------------------------------------------------------------------
module ifetch_mem_responder #(
    parameter int unsigned DEPTH_LINES  = 256,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic                           core_clk_main_800mhz,
    input  logic                           core_reset_async_n,
    input  logic [31:0]                    req_addr,
    input  logic                           req_valid,
    output logic                           req_ready,
    output logic [127:0]                   rsp_data,
    output logic                           rsp_valid,
    output logic                           rsp_error,
    input  logic                           flush,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_LINES)-1:0] load_index,
    input  logic [127:0]                   load_data,
`ifdef IFETCH_RESP_PARITY_EN
    input  logic                           parity_inject,
`endif
    output logic                           init_done
);

    localparam int unsigned   AW       = $clog2(DEPTH_LINES);
    localparam int unsigned   LAT      = READ_LATENCY;
    localparam logic [31:0]   SPAN     = 32'(DEPTH_LINES * 16);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_LINES - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   init_idx_q, init_idx_d;
    logic            init_done_q, init_done_d;

    logic [127:0]    mem_q [DEPTH_LINES];

    logic            accept;
    logic            flush_eff;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [127:0]    mem_wd;

    logic [32:0]     off_ext;
    logic            in_range;
    logic [AW-1:0]   rd_line;
    logic [127:0]    rd_data;
    logic            rd_err;

    logic [LAT-1:0]  vld_q;
    logic [LAT-1:0]  err_q;
    logic [127:0]    data_q [LAT];

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge core_clk_main_800mhz or negedge core_reset_async_n) begin
        if (!core_reset_async_n) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + AW'(1);
                if (init_idx_q == LAST_IDX) begin
                    init_idx_d  = '0;
                    init_done_d = 1'b1;
                    state_d     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                state_d = ST_SERVE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign req_ready = (state_q == ST_SERVE) & ~load_en;
    assign accept    = req_valid & req_ready;
    assign flush_eff = flush & (state_q == ST_SERVE);
    assign init_done = init_done_q;

    // ------------------------------------------------------------------------
    // Memory write port: clear during INIT, preload during SERVE
    // ------------------------------------------------------------------------
    always_comb begin
        mem_we = 1'b0;
        mem_wa = init_idx_q;
        mem_wd = '0;
        if (state_q == ST_INIT) begin
            mem_we = 1'b1;
        end else if (load_en) begin
            mem_we = 1'b1;
            mem_wa = load_index;
            mem_wd = load_data;
        end
    end

    always_ff @(posedge core_clk_main_800mhz) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // ------------------------------------------------------------------------
    // Address decode. The 33-bit subtract gives the borrow that flags
    // req_addr < BASE_ADDR, alongside the 32-bit wrapped offset.
    // ------------------------------------------------------------------------
    assign off_ext  = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign in_range = ~off_ext[32] & (off_ext[31:0] < SPAN);
    assign rd_line  = off_ext[4 +: AW];
    assign rd_data  = in_range ? mem_q[rd_line] : '0;

`ifdef IFETCH_RESP_PARITY_EN
    logic [3:0] mem_par_q [DEPTH_LINES];
    logic [3:0] wr_par;
    logic       par_err;

    function automatic logic [3:0] word_par(input logic [127:0] d);
        logic [3:0] p;
        for (int w = 0; w < 4; w++) begin
            p[w] = ^d[32*w +: 32];
        end
        return p;
    endfunction

    // Injection only applies to preloads; cleared lines always get good parity.
    assign wr_par = word_par(mem_wd) ^ {4{parity_inject & (state_q == ST_SERVE)}};

    always_ff @(posedge core_clk_main_800mhz) begin
        if (mem_we) begin
            mem_par_q[mem_wa] <= wr_par;
        end
    end

    assign par_err = in_range & (mem_par_q[rd_line] != word_par(mem_q[rd_line]));
    assign rd_err  = ~in_range | par_err;
`else
    assign rd_err  = ~in_range;
`endif

    // ------------------------------------------------------------------------
    // Response pipeline. Stage 0 captures the read in the accept cycle; the
    // last stage drives the outputs. Data/error only advance with a valid
    // entry so the outputs hold the last delivered response, and a flushed
    // entry never overwrites them.
    // ------------------------------------------------------------------------
    always_ff @(posedge core_clk_main_800mhz or negedge core_reset_async_n) begin
        if (!core_reset_async_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= accept;
            if (accept) begin
                data_q[0] <= rd_data;
                err_q[0]  <= rd_err;
            end
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1] & ~flush_eff;
                if (vld_q[i-1] & ~flush_eff) begin
                    data_q[i] <= data_q[i-1];
                    err_q[i]  <= err_q[i-1];
                end
            end
        end
    end

    assign rsp_valid = vld_q[LAT-1];
    assign rsp_data  = data_q[LAT-1];
    assign rsp_error = err_q[LAT-1];

endmodule
